// File: rtl/moving_average_mc_if.sv
// Sample-tick / data bus of the multi-channel moving-average filter.
// The master drives samples and configuration; the slave returns filtered results.
interface moving_average_mc_if #(
   parameter int DWIDTH         = 16,
   parameter int CHANNELS       = 2,
   parameter int MAX_DEPTH_LOG2 = 5
);
   localparam int KW = $clog2(MAX_DEPTH_LOG2 + 1);

   logic                         sample_tick_i;
   logic                         enable_i;
   logic [KW-1:0]                depth_log2_i;
   logic [CHANNELS*DWIDTH-1:0]   data_i;
   logic [CHANNELS*DWIDTH-1:0]   data_o;
   logic                         data_valid_o;
   logic                         overrun_o;

   modport master (
      output sample_tick_i, enable_i, depth_log2_i, data_i,
      input  data_o, data_valid_o, overrun_o
   );

   modport slave (
      input  sample_tick_i, enable_i, depth_log2_i, data_i,
      output data_o, data_valid_o, overrun_o
   );
endinterface

// File: rtl/moving_average_mc.sv
// Multi-channel moving-average filter: per-channel circular history plus a recursive
// running sum, one channel per cycle over a shared adder, rounded power-of-two mean.
module moving_average_mc #(
   parameter int DWIDTH         = 16,
   parameter int CHANNELS       = 2,
   parameter int MAX_DEPTH_LOG2 = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   moving_average_mc_if.slave bus
);
   localparam int DEPTH = 1 << MAX_DEPTH_LOG2;
   localparam int SW    = DWIDTH + MAX_DEPTH_LOG2;
   localparam int KW    = $clog2(MAX_DEPTH_LOG2 + 1);
   localparam int FW    = MAX_DEPTH_LOG2 + 1;
   localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int W     = CHANNELS * DWIDTH;

   typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              ch_q;
   logic [W-1:0]               lat_data_q;
   logic                       lat_en_q;
   logic [KW-1:0]              cur_k_q;
   logic [MAX_DEPTH_LOG2-1:0]  wptr_q;
   logic [FW-1:0]              fill_q;
   logic signed [SW-1:0]       sum_q  [CHANNELS];
   logic signed [DWIDTH-1:0]   hist_q [CHANNELS][DEPTH];
   logic [DWIDTH-1:0]          res_q  [CHANNELS];
   logic [W-1:0]               data_o_q;
   logic                       overrun_q;

   logic [KW-1:0]              k_req;
   logic                       last_ch;
   logic [FW-1:0]              win_len;
   logic [MAX_DEPTH_LOG2-1:0]  rd_idx;
   logic signed [DWIDTH-1:0]   new_s, oldest;
   logic signed [SW-1:0]       sum_new;
   logic [SW:0]                bias;
   logic signed [SW:0]         rounded;
   logic [DWIDTH-1:0]          mean;
   logic [W-1:0]               data_o_d;

   assign k_req   = (bus.depth_log2_i > KW'(MAX_DEPTH_LOG2)) ? KW'(MAX_DEPTH_LOG2) : bus.depth_log2_i;
   assign last_ch = (ch_q == CW'(CHANNELS - 1));

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.sample_tick_i) state_d = ST_CALC;
         ST_CALC: if (last_ch)           state_d = ST_DONE;
         ST_DONE:                        state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // Output logic: the valid pulse is the DONE state itself.
   always_comb begin
      bus.data_o       = data_o_q;
      bus.data_valid_o = (state_q == ST_DONE);
      bus.overrun_o    = overrun_q;
   end

   // Shared channel datapath; oldest sample only leaves the sum once the window is full.
   always_comb begin
      win_len  = FW'(1) << cur_k_q;
      rd_idx   = wptr_q - win_len[MAX_DEPTH_LOG2-1:0];
      new_s    = lat_data_q[ch_q*DWIDTH +: DWIDTH];
      oldest   = (fill_q >= win_len) ? hist_q[ch_q][rd_idx] : '0;
      sum_new  = sum_q[ch_q] + SW'(new_s) - SW'(oldest);
      bias     = (cur_k_q == '0) ? '0 : ((SW+1)'(1) << (cur_k_q - 1'b1));
      rounded  = (SW+1)'(sum_new) + signed'(bias);
      mean     = DWIDTH'(rounded >>> cur_k_q);
      data_o_d = '0;
      for (int c = 0; c < CHANNELS; c++)
         data_o_d[c*DWIDTH +: DWIDTH] = (ch_q == CW'(c)) ? mean : res_q[c];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: history must read as zero after reset, so it lives in resettable flops, not RAM.
         for (int c = 0; c < CHANNELS; c++) begin
            sum_q[c] <= '0;
            res_q[c] <= '0;
            for (int i = 0; i < DEPTH; i++) hist_q[c][i] <= '0;
         end
         ch_q       <= '0;
         lat_data_q <= '0;
         lat_en_q   <= 1'b0;
         cur_k_q    <= '0;
         wptr_q     <= '0;
         fill_q     <= '0;
         data_o_q   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
         if (bus.sample_tick_i && state_q != ST_IDLE) overrun_q <= 1'b1;
         case (state_q)
            ST_IDLE: if (bus.sample_tick_i) begin
               lat_data_q <= bus.data_i;
               lat_en_q   <= bus.enable_i;
               ch_q       <= '0;
               // A new window length restarts the averages; history and pointer survive.
               if (k_req != cur_k_q) begin
                  cur_k_q <= k_req;
                  fill_q  <= '0;
                  for (int c = 0; c < CHANNELS; c++) sum_q[c] <= '0;
               end
            end
            ST_CALC: begin
               sum_q[ch_q]          <= sum_new;
               hist_q[ch_q][wptr_q] <= new_s;
               res_q[ch_q]          <= mean;
               ch_q                 <= ch_q + 1'b1;
               if (last_ch) data_o_q <= lat_en_q ? data_o_d : lat_data_q;
            end
            ST_DONE: begin
               wptr_q <= wptr_q + 1'b1;
               if (fill_q != FW'(DEPTH)) fill_q <= fill_q + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_moving_average_mc.sv
// Bench for moving_average_mc: directed plan with literal expectations plus random ticks,
// all outputs compared every cycle against a window-of-samples reference model.
module tb_moving_average_mc;
   localparam int DW  = 16;
   localparam int CH  = 2;
   localparam int MDL = 5;
   localparam int KW  = $clog2(MDL + 1);
   localparam int W   = CH * DW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   moving_average_mc_if #(.DWIDTH(DW), .CHANNELS(CH), .MAX_DEPTH_LOG2(MDL)) bus ();

   moving_average_mc #(.DWIDTH(DW), .CHANNELS(CH), .MAX_DEPTH_LOG2(MDL)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      int           due;
      logic [W-1:0] data;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] seg_q[$];   // accepted sample sets since the last window change
   logic [W-1:0] model_out;
   bit           exp_ovr;
   int           m_k;
   int           last_p;

   task automatic check(input string name, input longint act, input longint req);
      n_chk++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_ch(input string name, input int c, input int lit);
      logic signed [DW-1:0] v;
      v = bus.data_o[c*DW +: DW];
      check(name, v, lit);
   endtask

   task automatic model_reset();
      exp_q.delete();
      seg_q.delete();
      model_out = '0;
      exp_ovr   = 1'b0;
      m_k       = 0;
      last_p    = -1000;
   endtask

   // Rounded mean of the last min(n, L) samples since the window was set.
   function automatic logic [DW-1:0] model_mean(input int c);
      longint s, num, q;
      int     len, n, m;
      logic [W-1:0]         v;
      logic signed [DW-1:0] x;
      len = 1 << m_k;
      n   = seg_q.size();
      m   = (n < len) ? n : len;
      s   = 0;
      for (int i = 0; i < m; i++) begin
         v = seg_q[n-1-i];
         x = v[c*DW +: DW];
         s += x;
      end
      if (m_k == 0) return DW'(s);
      num = s + len / 2;
      q   = num / len;
      if ((num % len) != 0 && num < 0) q -= 1;
      return DW'(q);
   endfunction

   task automatic model_tick(input logic [W-1:0] d, input bit en, input int k, input int p);
      exp_t e;
      int   kc;
      if (p - last_p < CH + 2) begin
         exp_ovr = 1'b1;
         return;
      end
      last_p = p;
      kc = (k > MDL) ? MDL : k;
      if (kc != m_k) begin
         m_k = kc;
         seg_q.delete();
      end
      seg_q.push_back(d);
      if (seg_q.size() > (1 << MDL)) void'(seg_q.pop_front());
      e.due  = p + CH;
      e.data = '0;
      for (int c = 0; c < CH; c++)
         e.data[c*DW +: DW] = en ? model_mean(c) : d[c*DW +: DW];
      exp_q.push_back(e);
   endtask

   // Called at #1 after an edge; the tick is captured by the next edge.
   task automatic do_tick(input logic [W-1:0] d, input bit en, input int k);
      bus.data_i        = d;
      bus.enable_i      = en;
      bus.depth_log2_i  = KW'(k);
      bus.sample_tick_i = 1'b1;
      @(posedge clk); #1;
      bus.sample_tick_i = 1'b0;
      bus.data_i        = W'($urandom());
      bus.enable_i      = 1'($urandom());
      bus.depth_log2_i  = KW'($urandom());
      model_tick(d, en, k, cyc);
   endtask

   // One tick every 8 cycles, optionally pinning the result to literals in the DONE cycle.
   task automatic run(input int v0, input int v1, input bit en, input int k,
                      input bit lit_on, input int lit0, input int lit1);
      do_tick({DW'(v1), DW'(v0)}, en, k);
      repeat (CH) @(posedge clk);
      #1;
      if (lit_on) begin
         check("lit_valid", bus.data_valid_o, 1);
         check_ch("lit_ch0", 0, lit0);
         check_ch("lit_ch1", 1, lit1);
      end
      repeat (8 - CH - 1) @(posedge clk);
      #1;
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("valid_pulse", bus.data_valid_o, 1);
            model_out = exp_q[0].data;
            void'(exp_q.pop_front());
         end else begin
            check("valid_idle", bus.data_valid_o, 0);
         end
         check("data_o", bus.data_o, model_out);
         check("overrun_o", bus.overrun_o, exp_ovr);
      end
   end

   initial begin
      int k;
      int gap;
      bus.sample_tick_i = 1'b0;
      bus.enable_i      = 1'b1;
      bus.depth_log2_i  = '0;
      bus.data_i        = '0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      check("rst_data_o", bus.data_o, 0);
      check("rst_valid", bus.data_valid_o, 0);
      check("rst_overrun", bus.overrun_o, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Ramp at k=2.
      run(4, 0, 1, 2, 1, 1, 0);
      run(8, 0, 1, 2, 1, 3, 0);
      run(12, 0, 1, 2, 1, 6, 0);
      run(16, 0, 1, 2, 1, 10, 0);
      run(20, 0, 1, 2, 1, 14, 0);

      // Negative rounding and channel independence at k=1.
      run(100, -3, 1, 1, 1, 50, -1);
      run(100, -3, 1, 1, 1, 100, -3);
      run(100, -3, 1, 1, 1, 100, -3);

      // Full scale at the deepest window.
      for (int i = 0; i < 40; i++) run(32767, 32767, 1, 5, i == 39, 32767, 32767);
      for (int i = 0; i < 40; i++) run(-32768, -32768, 1, 5, i == 39, -32768, -32768);

      // Depth change with ramp-in; a requested 7 would clamp, here exercise 2 -> 1 -> 2.
      run(8, 8, 1, 2, 1, 2, 2);
      run(8, 8, 1, 2, 1, 4, 4);
      run(8, 8, 1, 2, 1, 6, 6);
      run(8, 8, 1, 2, 1, 8, 8);
      run(8, 8, 1, 1, 1, 4, 4);
      run(8, 8, 1, 1, 1, 8, 8);
      run(8, 8, 1, 2, 1, 2, 2);
      run(8, 8, 1, 2, 1, 4, 4);
      run(8, 8, 1, 2, 1, 6, 6);
      run(8, 8, 1, 2, 1, 8, 8);

      // Bypass, then re-enable at k=0.
      run(1000, 1000, 0, 2, 1, 1000, 1000);
      run(-5, -5, 0, 2, 1, -5, -5);
      run(7, 7, 1, 0, 1, 7, 7);

      // Out-of-range depth clamps to the maximum.
      run(64, 32, 1, 7, 1, 2, 1);

      // Overrun: second tick two cycles after the first is dropped.
      do_tick({DW'(22), DW'(11)}, 1, 0);
      @(posedge clk); #1;
      do_tick({DW'(99), DW'(99)}, 1, 0);
      check("ovr_valid", bus.data_valid_o, 1);
      check_ch("ovr_ch0", 0, 11);
      check_ch("ovr_ch1", 1, 22);
      check("ovr_flag", bus.overrun_o, 1);
      repeat (6) @(posedge clk); #1;

      // Asynchronous reset in the middle of a calculation.
      do_tick({DW'(66), DW'(55)}, 1, 0);
      #1;
      rst = 1'b1;
      #1;
      model_reset();
      check("mid_rst_data_o", bus.data_o, 0);
      check("mid_rst_valid", bus.data_valid_o, 0);
      check("mid_rst_overrun", bus.overrun_o, 0);
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b0;
      @(posedge clk); #1;
      run(7, 9, 1, 0, 1, 7, 9);
      run(6, 6, 1, 1, 1, 3, 3);

      // Random ticks; the second half allows spacing tight enough to overrun.
      k = 2;
      for (int i = 0; i < 300; i++) begin
         gap = (i < 150) ? $urandom_range(4, 12) : $urandom_range(2, 12);
         repeat (gap - 1) @(posedge clk);
         #1;
         if ($urandom_range(0, 15) == 0) k = $urandom_range(0, 7);
         do_tick(W'($urandom()), $urandom_range(0, 4) != 0, k);
      end

      repeat (10) @(posedge clk);
      #1;
      check("drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
